// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer owning the program counter.
// Fetches over a req/ack port, decodes the opcode and hands ALU work to the datapath.
module pc_sequencer #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ex_start,
  input  logic               ex_done,
  input  logic [3:0]         alu_result,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ir,
  output logic               halted,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    FETCH2,
    EXEC,
    HALT
  } state_t;

  localparam logic [3:0] OP_HALT   = 4'h0;
  localparam logic [3:0] OP_JUMP   = 4'h5;
  localparam logic [3:0] OP_BRANCH = 4'h6;

  state_t          state;
  logic [7:0]      offset;
  logic [3:0]      op;
  logic [PC_W-1:0] jump_target;
  logic [PC_W-1:0] exec_next_pc;

  assign op          = ir[INSTR_W-1 -: 4];
  assign jump_target = PC_W'(ir[7:0]);

  // Offset is unsigned; all PC arithmetic wraps at 2^PC_W.
  always_comb begin
    exec_next_pc = pc + PC_W'(1);
    if (op == OP_BRANCH) begin
      if (alu_result == 4'd1) begin
        exec_next_pc = pc + PC_W'(offset) + PC_W'(2);
      end else begin
        exec_next_pc = pc + PC_W'(2);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      offset    <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      ex_start  <= 1'b0;
      halted    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ex_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state     <= FETCH;
            imem_req  <= 1'b1;
            imem_addr <= pc;
            busy      <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= DECODE;
          end
        end
        DECODE: begin
          case (op)
            OP_HALT: begin
              state  <= HALT;
              halted <= 1'b1;
              busy   <= 1'b0;
            end
            OP_JUMP: begin
              pc <= jump_target;
              if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state     <= FETCH;
                imem_req  <= 1'b1;
                imem_addr <= jump_target;
              end
            end
            OP_BRANCH: begin
              state     <= FETCH2;
              imem_req  <= 1'b1;
              imem_addr <= pc + PC_W'(1);
            end
            default: begin
              state    <= EXEC;
              ex_start <= 1'b1;
            end
          endcase
        end
        FETCH2: begin
          if (imem_ack) begin
            offset   <= imem_rdata[7:0];
            imem_req <= 1'b0;
            state    <= EXEC;
            ex_start <= 1'b1;
          end
        end
        EXEC: begin
          // ex_start is still high on the first EXEC cycle, so a coincident ex_done is dropped.
          if (ex_done && !ex_start) begin
            pc <= exec_next_pc;
            if (stop) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state     <= FETCH;
              imem_req  <= 1'b1;
              imem_addr <= exec_next_pc;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural instruction memory and
// datapath responder, both with programmable latency.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata = 16'h0;
  logic        ex_start;
  logic        ex_done;
  logic [3:0]  alu_result = 4'd0;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic        halted;
  logic        busy;

  pc_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ex_start   (ex_start),
    .ex_done    (ex_done),
    .alu_result (alu_result),
    .pc         (pc),
    .ir         (ir),
    .halted     (halted),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:255];
  int          mem_delay = 0;
  int          ex_delay = 0;
  bit          early_done = 1'b0;
  logic        model_ack = 1'b0;
  logic        model_done = 1'b0;
  logic        stray_ack = 1'b0;
  logic        stray_done = 1'b0;
  int          wcnt = 0;
  int          ecnt = 0;
  bit          pending = 1'b0;
  logic [7:0]  first_addr = 8'h0;
  int          fetch_n = 0;
  int          ex_count = 0;
  int          stable_err = 0;
  logic [7:0]  fetch_log [0:255];

  assign imem_ack = model_ack | stray_ack;
  assign ex_done  = model_done | stray_done;

  // Responders act on the falling edge so the DUT sees stable inputs at the rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_ack  <= 1'b0;
      model_done <= 1'b0;
      wcnt       <= 0;
      ecnt       <= 0;
      pending    <= 1'b0;
    end else begin
      model_ack <= 1'b0;
      if (imem_req) begin
        if (wcnt == 0) first_addr <= imem_addr;
        else if (imem_addr !== first_addr) stable_err <= stable_err + 1;
        if (wcnt >= mem_delay) begin
          model_ack             <= 1'b1;
          imem_rdata            <= mem[imem_addr];
          fetch_log[fetch_n[7:0]] <= imem_addr;
          fetch_n               <= fetch_n + 1;
          wcnt                  <= 0;
        end else begin
          wcnt <= wcnt + 1;
        end
      end else begin
        if (wcnt != 0) stable_err <= stable_err + 1;
        wcnt <= 0;
      end

      model_done <= 1'b0;
      if (ex_start) begin
        ex_count   <= ex_count + 1;
        pending    <= 1'b1;
        ecnt       <= 0;
        model_done <= early_done;
      end else if (pending) begin
        if (ecnt >= ex_delay) begin
          model_done <= 1'b1;
          pending    <= 1'b0;
        end else begin
          ecnt <= ecnt + 1;
        end
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int max);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check(tag, 32'(halted), 32'd1);
  endtask

  int f0;
  int e0;
  int n;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000;

    // T1: reset state, then halt at word 0
    mem[8'h00] = 16'h0000;
    rst_n = 1'b0;
    tick();
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_ir", 32'(ir), 32'h0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'h0);
    check("rst_ex_start", 32'(ex_start), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    f0 = fetch_n;
    e0 = ex_count;
    start_run();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_req", 32'(imem_req), 32'd1);
    wait_halt("t1_halt", 20);
    check("t1_busy_halt", 32'(busy), 32'd0);
    check("t1_pc", 32'(pc), 32'h00);
    check("t1_fetches", 32'(fetch_n - f0), 32'd1);
    check("t1_fetch_addr", 32'(fetch_log[f0[7:0]]), 32'h00);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    tick();
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("t1_sticky", 32'(halted), 32'd1);
    check("t1_no_refetch", 32'(fetch_n - f0), 32'd1);
    check("t1_no_ex", 32'(ex_count - e0), 32'd0);

    // T2: absolute jump to A0, which halts
    mem[8'h00] = 16'h50A0;
    mem[8'hA0] = 16'h0000;
    do_reset();
    check("t2_ir_cleared", 32'(ir), 32'h0);
    f0 = fetch_n;
    e0 = ex_count;
    start_run();
    tick();
    tick();
    check("t2_pc_jump", 32'(pc), 32'hA0);
    check("t2_req", 32'(imem_req), 32'd1);
    check("t2_addr", 32'(imem_addr), 32'hA0);
    wait_halt("t2_halt", 20);
    check("t2_pc_final", 32'(pc), 32'hA0);
    check("t2_fetch1", 32'(fetch_log[8'(f0 + 1)]), 32'hA0);
    check("t2_no_ex", 32'(ex_count - e0), 32'd0);

    // T3: branch at 10, offset 5, taken then not taken
    mem[8'h00] = 16'h5010;
    mem[8'h10] = 16'h6000;
    mem[8'h11] = 16'h0005;
    mem[8'h17] = 16'h0000;
    mem[8'h12] = 16'h0000;
    alu_result = 4'd1;
    do_reset();
    f0 = fetch_n;
    e0 = ex_count;
    start_run();
    wait_halt("t3_halt_taken", 40);
    check("t3_pc_taken", 32'(pc), 32'h17);
    check("t3_fetches", 32'(fetch_n - f0), 32'd4);
    check("t3_fetch_br", 32'(fetch_log[8'(f0 + 1)]), 32'h10);
    check("t3_fetch_off", 32'(fetch_log[8'(f0 + 2)]), 32'h11);
    check("t3_ex_pulses", 32'(ex_count - e0), 32'd1);
    alu_result = 4'd3;
    do_reset();
    e0 = ex_count;
    start_run();
    wait_halt("t3_halt_not_taken", 40);
    check("t3_pc_not_taken", 32'(pc), 32'h12);
    check("t3_ex_pulses_nt", 32'(ex_count - e0), 32'd1);

    // T4: taken branch wraps past FF
    mem[8'h00] = 16'h50FE;
    mem[8'hFE] = 16'h6000;
    mem[8'hFF] = 16'h0005;
    mem[8'h05] = 16'h0000;
    alu_result = 4'd1;
    do_reset();
    start_run();
    wait_halt("t4_halt_wrap", 40);
    check("t4_pc_wrap", 32'(pc), 32'h05);

    // T4/T6: plain op at FF wraps to 00, stop during EXEC wait returns to IDLE
    mem[8'h00] = 16'h50FF;
    mem[8'hFF] = 16'h1000;
    ex_delay = 5;
    do_reset();
    e0 = ex_count;
    start_run();
    n = 0;
    while (ex_count == e0 && n < 20) begin
      tick();
      n++;
    end
    check("t6_ex_seen", 32'(ex_count - e0), 32'd1);
    stop = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    stop = 1'b0;
    check("t6_idle_after_stop", 32'(busy), 32'd0);
    check("t4_pc_plain_wrap", 32'(pc), 32'h00);
    check("t6_not_halted", 32'(halted), 32'd0);
    check("t6_req_low", 32'(imem_req), 32'd0);
    f0 = fetch_n;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    tick();
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("t6_start_stop_idle", 32'(busy), 32'd0);
    check("t6_no_fetch", 32'(fetch_n - f0), 32'd0);

    // T5: 3-cycle fetch latency, early ex_done ignored, 5-cycle ex wait
    mem[8'h00] = 16'h1234;
    mem[8'h01] = 16'h0000;
    mem_delay  = 3;
    ex_delay   = 5;
    early_done = 1'b1;
    do_reset();
    e0 = ex_count;
    start_run();
    check("t5_req_c0", 32'(imem_req), 32'd1);
    check("t5_addr_c0", 32'(imem_addr), 32'h00);
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("t5_req_c%0d", i), 32'(imem_req), 32'd1);
      check($sformatf("t5_addr_c%0d", i), 32'(imem_addr), 32'h00);
    end
    tick();
    check("t5_req_drop", 32'(imem_req), 32'd0);
    check("t5_ir", 32'(ir), 32'h1234);
    tick();
    check("t5_ex_start", 32'(ex_start), 32'd1);
    tick();
    check("t5_ex_start_pulse", 32'(ex_start), 32'd0);
    check("t5_early_done_ignored", 32'(pc), 32'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t5_pc_wait%0d", i), 32'(pc), 32'h00);
    end
    tick();
    check("t5_pc_commit", 32'(pc), 32'h01);
    early_done = 1'b0;
    wait_halt("t5_halt", 40);
    check("t5_single_ex", 32'(ex_count - e0), 32'd1);
    check("t5_stable", 32'(stable_err), 32'd0);

    // T6: reset in the middle of a fetch, then stray handshakes
    mem[8'h00] = 16'h5033;
    mem_delay  = 10;
    ex_delay   = 0;
    do_reset();
    start_run();
    n = 0;
    while (!(imem_req === 1'b1 && imem_addr === 8'h33) && n < 40) begin
      tick();
      n++;
    end
    check("t6_fetch_33", 32'(imem_addr), 32'h33);
    check("t6_pc_33", 32'(pc), 32'h33);
    rst_n = 1'b0;
    #1;
    check("t6_req_async", 32'(imem_req), 32'd0);
    check("t6_pc_async", 32'(pc), 32'h00);
    check("t6_busy_async", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    f0 = fetch_n;
    stray_ack  = 1'b1;
    stray_done = 1'b1;
    tick();
    tick();
    stray_ack  = 1'b0;
    stray_done = 1'b0;
    tick();
    check("t6_stray_ir", 32'(ir), 32'h0);
    check("t6_stray_pc", 32'(pc), 32'h00);
    check("t6_stray_busy", 32'(busy), 32'd0);
    check("t6_stray_req", 32'(imem_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
